// File: rtl/pipelined_memory.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_memory
// Description : Single-port synchronous RAM with valid/ready request and
//               read-response channels, byte-lane writes and a read pipeline
//               of configurable depth.
// Revision    : 1.0 - initial release
// ============================================================================
module pipelined_memory #(
    parameter int ADDRESS_WIDTH            = 15,
    parameter int DATA_WIDTH               = 32,
    parameter int DEPTH                    = 2**ADDRESS_WIDTH,
    parameter int READ_LATENCY             = 1,
    parameter     INITIAL_MEMORY_DATA_PATH = ""
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [ADDRESS_WIDTH-1:0]  req_address,
    input  logic [DATA_WIDTH/8-1:0]   req_byte_enable,
    input  logic [DATA_WIDTH-1:0]     req_write_data,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [DATA_WIDTH-1:0]     resp_data,
    output logic                      resp_error
);

    localparam int c_LANES = DATA_WIDTH / 8;
    localparam int c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDRESS_WIDTH:0] c_DEPTH = (ADDRESS_WIDTH + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0]   r_mem [0:DEPTH-1];

    logic [READ_LATENCY-1:0] r_valid;
    logic [READ_LATENCY-1:0] r_error;
    logic [DATA_WIDTH-1:0]   r_data [0:READ_LATENCY-1];

    logic                    w_stall;
    logic                    w_fire;
    logic                    w_rd_fire;
    logic                    w_wr_fire;
    logic                    w_in_range;
    logic [c_IDX_W-1:0]      w_index;
    logic [DATA_WIDTH-1:0]   w_rd_data;

    // Backpressure from the consumer reaches req_ready combinationally.
    assign w_stall    = r_valid[READ_LATENCY-1] && !resp_ready;
    assign req_ready  = !w_stall && !reset;
    assign w_fire     = req_valid && req_ready;
    assign w_in_range = ({1'b0, req_address} < c_DEPTH);
    assign w_index    = req_address[c_IDX_W-1:0];
    assign w_rd_fire  = w_fire && !req_write;
    assign w_wr_fire  = w_fire && req_write && w_in_range;
    assign w_rd_data  = w_in_range ? r_mem[w_index] : '0;

    // Array contents are deliberately not reset.
    always_ff @(posedge clock) begin
        if (w_wr_fire) begin
            for (int b = 0; b < c_LANES; b++) begin
                if (req_byte_enable[b]) begin
                    r_mem[w_index][8*b +: 8] <= req_write_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid <= '0;
            r_error <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_data[i] <= '0;
            end
        end else if (!w_stall) begin
            r_valid[0] <= w_rd_fire;
            if (w_rd_fire) begin
                r_data[0]  <= w_rd_data;
                r_error[0] <= !w_in_range;
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_valid[i] <= r_valid[i-1];
                r_data[i]  <= r_data[i-1];
                r_error[i] <= r_error[i-1];
            end
        end
    end

    assign resp_valid = r_valid[READ_LATENCY-1];
    assign resp_data  = r_data[READ_LATENCY-1];
    assign resp_error = r_error[READ_LATENCY-1];

endmodule
`default_nettype wire

// File: tb/tb_pipelined_memory.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipelined_memory
// Description : Self-checking bench for pipelined_memory with a queue-based
//               reference model of the array and the in-flight reads.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_memory;

    localparam int AW    = 7;
    localparam int DW    = 32;
    localparam int DEPTH = 100;
    localparam int LAT   = 3;

    logic          clock;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_address;
    logic [3:0]    req_byte_enable;
    logic [DW-1:0] req_write_data;
    logic          resp_valid;
    logic          resp_ready;
    logic [DW-1:0] resp_data;
    logic          resp_error;

    pipelined_memory #(
        .ADDRESS_WIDTH (AW),
        .DATA_WIDTH    (DW),
        .DEPTH         (DEPTH),
        .READ_LATENCY  (LAT)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_write       (req_write),
        .req_address     (req_address),
        .req_byte_enable (req_byte_enable),
        .req_write_data  (req_write_data),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_data       (resp_data),
        .resp_error      (resp_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          waitc;
    } pend_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } obs_t;

    logic [31:0] mdl [0:DEPTH-1];
    pend_t       q[$];
    obs_t        obs[$];
    int          n_tests  = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    bit          meas_on  = 0;
    int          acc_cyc  = -1;
    int          val_cyc  = -1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle: check outputs against the model, then advance the model
    // across the rising edge using the request driven for this cycle.
    task automatic tick();
        bit          exp_valid, exp_stall, exp_ready, accept, wr;
        int          a;
        logic [3:0]  be;
        logic [31:0] wd;
        pend_t       p;
        obs_t        o;
        #1;
        exp_valid = (q.size() > 0) && (q[0].waitc == 0);
        exp_stall = exp_valid && !resp_ready;
        exp_ready = !exp_stall && !reset;
        chk("req_ready", {31'd0, req_ready}, {31'd0, exp_ready});
        chk("resp_valid", {31'd0, resp_valid}, {31'd0, exp_valid});
        if (exp_valid) begin
            chk("resp_data", resp_data, q[0].data);
            chk("resp_error", {31'd0, resp_error}, {31'd0, q[0].err});
        end
        if (resp_valid && resp_ready) begin
            o.data = resp_data; o.err = resp_error; o.cyc = cyc;
            obs.push_back(o);
        end
        if (meas_on && resp_valid && val_cyc < 0) val_cyc = cyc;
        accept = req_valid && exp_ready;
        wr     = req_write;
        a      = int'(req_address);
        be     = req_byte_enable;
        wd     = req_write_data;
        if (meas_on && accept && !wr && acc_cyc < 0) acc_cyc = cyc;
        @(posedge clock);
        if (reset) begin
            q.delete();
        end else if (!exp_stall) begin
            if (exp_valid && resp_ready) void'(q.pop_front());
            foreach (q[i]) if (q[i].waitc > 0) q[i].waitc = q[i].waitc - 1;
            if (accept) begin
                if (wr) begin
                    if (a < DEPTH)
                        for (int b = 0; b < 4; b++)
                            if (be[b]) mdl[a][8*b +: 8] = wd[8*b +: 8];
                end else begin
                    p.data  = (a < DEPTH) ? mdl[a] : 32'd0;
                    p.err   = (a >= DEPTH);
                    p.waitc = LAT - 1;
                    q.push_back(p);
                end
            end
        end
        cyc++;
        @(negedge clock);
    endtask

    task automatic issue(input bit wr, input int a, input logic [3:0] be, input logic [31:0] d);
        req_valid       = 1'b1;
        req_write       = wr;
        req_address     = AW'(a);
        req_byte_enable = be;
        req_write_data  = d;
        tick();
    endtask

    task automatic idle();
        req_valid = 1'b0;
        tick();
    endtask

    task automatic expect_resp(input string tag, input logic [31:0] d, input logic e);
        obs_t o;
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        for (int i = 0; i < 20 && obs.size() == 0; i++) tick();
        chk({tag, "_present"}, obs.size() > 0 ? 32'd1 : 32'd0, 32'd1);
        if (obs.size() > 0) begin
            o = obs.pop_front();
            chk({tag, "_data"}, o.data, d);
            chk({tag, "_err"}, {31'd0, o.err}, {31'd0, e});
        end
    endtask

    task automatic drain();
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        for (int i = 0; i < 50 && q.size() > 0; i++) tick();
        chk("drain_empty", q.size(), 32'd0);
    endtask

    initial begin
        obs_t o;
        int   prev;
        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_address = '0;
        req_byte_enable = 4'h0; req_write_data = '0; resp_ready = 1'b1;
        @(negedge clock);

        // Power-on reset
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("reset_resp_data", resp_data, 32'd0);
        chk("reset_resp_error", {31'd0, resp_error}, 32'd0);
        chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clock);

        // Fill the array with value = address
        for (int a = 0; a < DEPTH; a++) issue(1'b1, a, 4'hF, 32'(a));
        issue(1'b1, 9, 4'hF, 32'd7);
        drain(); obs.delete();

        // Back-to-back reads 0..7: first response after LAT cycles, then 8 in a row
        meas_on = 1;
        for (int a = 0; a < 8; a++) issue(1'b0, a, 4'h0, 32'd0);
        idle(); idle(); idle(); idle();
        meas_on = 0;
        chk("latency", 32'(val_cyc - acc_cyc), 32'(LAT));
        prev = -1;
        for (int i = 0; i < 8; i++) begin
            if (obs.size() > 0) begin
                o = obs[0];
                if (prev >= 0) chk("lat_consecutive", 32'(o.cyc), 32'(prev + 1));
                prev = o.cyc;
            end
            expect_resp("lat_seq", 32'(i), 1'b0);
        end
        drain(); obs.delete();

        // Byte-lane write merge
        issue(1'b1, 5, 4'b1111, 32'hAABBCCDD);
        issue(1'b1, 5, 4'b0101, 32'h11223344);
        issue(1'b0, 5, 4'h0, 32'd0);
        expect_resp("byte_lane", 32'hAA22CC44, 1'b0);
        drain(); obs.delete();

        // Backpressure: hold the first response for 4 cycles while a write is offered
        issue(1'b0, 1, 4'h0, 32'd0);
        issue(1'b0, 2, 4'h0, 32'd0);
        issue(1'b0, 3, 4'h0, 32'd0);
        resp_ready = 1'b0;
        req_valid = 1'b1; req_write = 1'b1; req_address = AW'(1);
        req_byte_enable = 4'hF; req_write_data = 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
            chk("bp_hold_data", resp_data, 32'd1);
            tick();
        end
        req_valid = 1'b0;
        expect_resp("bp_1", 32'd1, 1'b0);
        expect_resp("bp_2", 32'd2, 1'b0);
        expect_resp("bp_3", 32'd3, 1'b0);
        issue(1'b0, 1, 4'h0, 32'd0);
        expect_resp("bp_no_write", 32'd1, 1'b0);
        drain(); obs.delete();

        // Read-after-write ordering
        issue(1'b0, 9, 4'h0, 32'd0);
        issue(1'b1, 9, 4'hF, 32'h55);
        issue(1'b0, 9, 4'h0, 32'd0);
        expect_resp("raw_old", 32'd7, 1'b0);
        expect_resp("raw_new", 32'h55, 1'b0);
        drain(); obs.delete();

        // Out-of-range access at DEPTH
        issue(1'b1, DEPTH, 4'hF, 32'hFF);
        issue(1'b0, DEPTH, 4'h0, 32'd0);
        issue(1'b0, DEPTH - 1, 4'h0, 32'd0);
        expect_resp("oor_hi", 32'd0, 1'b1);
        expect_resp("oor_last", 32'd99, 1'b0);
        drain(); obs.delete();

        // Reset with three reads in flight
        resp_ready = 1'b0;
        issue(1'b0, 10, 4'h0, 32'd0);
        issue(1'b0, 11, 4'h0, 32'd0);
        issue(1'b0, 12, 4'h0, 32'd0);
        req_valid = 1'b0;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        resp_ready = 1'b1;
        #1;
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        @(negedge clock);
        for (int i = 0; i < 6; i++) idle();
        chk("rst_no_resp", obs.size(), 32'd0);
        issue(1'b0, 10, 4'h0, 32'd0);
        issue(1'b0, 11, 4'h0, 32'd0);
        issue(1'b0, 12, 4'h0, 32'd0);
        expect_resp("rst_mem10", 32'd10, 1'b0);
        expect_resp("rst_mem11", 32'd11, 1'b0);
        expect_resp("rst_mem12", 32'd12, 1'b0);
        drain(); obs.delete();

        // Randomized mixed traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            req_valid       = ($urandom % 4) != 0;
            req_write       = $urandom % 2;
            req_address     = AW'($urandom_range(0, DEPTH + 9));
            req_byte_enable = 4'($urandom);
            req_write_data  = $urandom;
            resp_ready      = ($urandom % 4) != 0;
            tick();
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
